proc_mem_arbiter: RTL and testbench

//  Shares the Processor's single-port data memory between the CPU load/store port and the display byte reader.
//  CPU has fixed priority. A wait counter guarantees the display a slot after DISP_MAX_WAIT blocked cycles.

---
 rtl/proc_mem_pkg.sv | 18 +
 rtl/rd_tag_pipe.sv | 30 +++
 rtl/proc_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_proc_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_mem_pkg.sv
// Shared types for the processor data-memory arbiter: read ownership and the read-return tag.
package proc_mem_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned STAT_W = 16;

  typedef enum logic {
    OWN_CPU,
    OWN_DISP
  } owner_t;

  typedef struct packed {
    logic         valid;
    owner_t       owner;
    logic [1:0]   byteOff;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register that carries a read tag alongside the RAM read latency.
module rd_tag_pipe
  import proc_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tagIn,
  output rd_tag_t tagOut
);

  rd_tag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= tagIn;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tagOut = stages[DEPTH-1];

endmodule

// File: rtl/proc_mem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store port and the display byte reader.
// Optional ARB_STATS_EN adds saturating conflict / forced-display-win counters.
module proc_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned DISP_MAX_WAIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                disp_req,
  input  logic [ADDR_W-1:0]   disp_addr,
  output logic                disp_gnt,
  output logic                disp_rvalid,
  output logic [BYTE_W-1:0]   disp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_conflicts,
  output logic [STAT_W-1:0]   stat_forced
`endif
);

  localparam int unsigned WAIT_W = $clog2(DISP_MAX_WAIT + 1);

  logic [WAIT_W-1:0] dispWait;
  logic              bothReq;
  logic              dispForced;
  logic              cpuWin;
  logic              dispWin;
  rd_tag_t           tagIn;
  rd_tag_t           tagOut;
  logic              cpuHit;
  logic              dispHit;
  logic [BYTE_W-1:0] selByte;
  logic [DATA_W-1:0] cpuRdataQ;
  logic [BYTE_W-1:0] dispRdataQ;
  logic [1:0]        unusedAddrBits;

  // The CPU byte offset is irrelevant: it always moves whole words.
  assign unusedAddrBits = cpu_addr[1:0];

  // CPU has priority unless the display has been starved long enough.
  always_comb begin
    bothReq    = cpu_req & disp_req;
    dispForced = bothReq & (dispWait >= WAIT_W'(DISP_MAX_WAIT));
    cpuWin     = ~rst & cpu_req & ~dispForced;
    dispWin    = ~rst & disp_req & (~cpu_req | dispForced);
  end

  assign cpu_gnt   = cpuWin;
  assign disp_gnt  = dispWin;
  assign mem_en    = cpuWin | dispWin;
  assign mem_we    = cpuWin & cpu_we;
  assign mem_addr  = dispWin ? disp_addr[ADDR_W-1:2] : cpu_addr[ADDR_W-1:2];
  assign mem_wdata = cpu_wdata;

  // Starvation counter: counts blocked display cycles, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      dispWait <= '0;
    end else if (disp_req & ~dispWin) begin
      if (dispWait < WAIT_W'(DISP_MAX_WAIT)) begin
        dispWait <= dispWait + WAIT_W'(1);
      end
    end else begin
      dispWait <= '0;
    end
  end

  always_comb begin
    tagIn         = '0;
    tagIn.valid   = dispWin | (cpuWin & ~cpu_we);
    tagIn.owner   = dispWin ? OWN_DISP : OWN_CPU;
    tagIn.byteOff = dispWin ? disp_addr[1:0] : 2'b00;
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) uTagPipe (
    .clk    (clk),
    .rst    (rst),
    .tagIn  (tagIn),
    .tagOut (tagOut)
  );

  // Return path: reads in flight while reset is asserted are dropped.
  assign cpuHit  = ~rst & tagOut.valid & (tagOut.owner == OWN_CPU);
  assign dispHit = ~rst & tagOut.valid & (tagOut.owner == OWN_DISP);
  assign selByte = mem_rdata[{tagOut.byteOff, 3'b000} +: BYTE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      cpuRdataQ  <= '0;
      dispRdataQ <= '0;
    end else begin
      if (cpuHit) begin
        cpuRdataQ <= mem_rdata;
      end
      if (dispHit) begin
        dispRdataQ <= selByte;
      end
    end
  end

  assign cpu_rvalid  = cpuHit;
  assign disp_rvalid = dispHit;
  assign cpu_rdata   = cpuHit ? mem_rdata : cpuRdataQ;
  assign disp_rdata  = dispHit ? selByte : dispRdataQ;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] conflictCnt;
  logic [STAT_W-1:0] forcedCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflictCnt <= '0;
      forcedCnt   <= '0;
    end else begin
      if (bothReq && (conflictCnt != {STAT_W{1'b1}})) begin
        conflictCnt <= conflictCnt + STAT_W'(1);
      end
      if (dispForced && (forcedCnt != {STAT_W{1'b1}})) begin
        forcedCnt <= forcedCnt + STAT_W'(1);
      end
    end
  end

  assign stat_conflicts = conflictCnt;
  assign stat_forced    = forcedCnt;
`endif

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Self-checking bench for proc_mem_arbiter: reference model of arbitration, RAM and read returns.
module tb_proc_mem_arbiter;

  localparam int RD_LAT        = 1;
  localparam int DISP_MAX_WAIT = 3;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic [7:0]  disp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_conflicts;
  logic [15:0] stat_forced;
`endif

  int nCmp  = 0;
  int nFail = 0;

  proc_mem_arbiter #(
    .ADDR_W        (16),
    .DATA_W        (32),
    .RD_LAT        (RD_LAT),
    .DISP_MAX_WAIT (DISP_MAX_WAIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_gnt        (cpu_gnt),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_rdata      (cpu_rdata),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_gnt       (disp_gnt),
    .disp_rvalid    (disp_rvalid),
    .disp_rdata     (disp_rdata),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .stat_conflicts (stat_conflicts),
    .stat_forced    (stat_forced)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle RAM behind the arbiter.
  logic [31:0] ram [16384];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: word memory, blocked-cycle count and a list of pending reads.
  typedef struct {
    int          due;
    bit          disp;
    logic [31:0] data;
  } pend_t;

  logic [31:0] modelMem [int];
  pend_t       pend [$];
  int          cyc = 0;
  int          blocked = 0;
  logic [31:0] holdCpu = '0;
  logic [7:0]  holdDisp = '0;
  int          mConf = 0;
  int          mForced = 0;

  always @(negedge clk) begin
    bit eC, eD, eCv, eDv, forced;
    pend_t p;
    eC = 0; eD = 0; eCv = 0; eDv = 0; forced = 0;
    if (!rst) begin
      if (cpu_req && disp_req) begin
        forced = (blocked >= DISP_MAX_WAIT);
        eD = forced;
        eC = !forced;
      end else begin
        eC = cpu_req;
        eD = disp_req;
      end
    end
    if (rst) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      if (p.disp) begin eDv = 1; holdDisp = p.data[7:0]; end
      else        begin eCv = 1; holdCpu  = p.data;      end
    end

    check("cpu_gnt",     32'(cpu_gnt),     32'(eC));
    check("disp_gnt",    32'(disp_gnt),    32'(eD));
    check("mem_en",      32'(mem_en),      32'(eC | eD));
    check("mem_we",      32'(mem_we),      32'(eC & cpu_we));
    if (eC | eD)
      check("mem_addr", 32'(mem_addr), eD ? 32'(disp_addr >> 2) : 32'(cpu_addr >> 2));
    if (eC && cpu_we)
      check("mem_wdata", mem_wdata, cpu_wdata);
    check("cpu_rvalid",  32'(cpu_rvalid),  32'(eCv));
    check("disp_rvalid", 32'(disp_rvalid), 32'(eDv));
    check("cpu_rdata",   cpu_rdata,        holdCpu);
    check("disp_rdata",  32'(disp_rdata),  32'(holdDisp));
`ifdef ARB_STATS_EN
    check("stat_conflicts", 32'(stat_conflicts), 32'(mConf));
    check("stat_forced",    32'(stat_forced),    32'(mForced));
`endif

    if (rst) begin
      blocked = 0; holdCpu = '0; holdDisp = '0; mConf = 0; mForced = 0;
    end else begin
      if (eC && cpu_we) begin
        modelMem[int'(cpu_addr) / 4] = cpu_wdata;
      end else if (eC) begin
        p.due = cyc + RD_LAT; p.disp = 0; p.data = modelMem[int'(cpu_addr) / 4];
        pend.push_back(p);
      end
      if (eD) begin
        p.due = cyc + RD_LAT; p.disp = 1;
        p.data = (modelMem[int'(disp_addr) / 4] >> (8 * (int'(disp_addr) % 4))) & 32'hFF;
        pend.push_back(p);
      end
      blocked = (disp_req && !eD) ? ((blocked + 1 > DISP_MAX_WAIT) ? DISP_MAX_WAIT : blocked + 1) : 0;
      if (cpu_req && disp_req && mConf < 16'hFFFF) mConf++;
      if (forced && mForced < 16'hFFFF) mForced++;
    end
    cyc++;
  end

  task automatic stepIn();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuOp(input logic we, input logic [15:0] a, input logic [31:0] d);
    int n;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    n = 0;
    @(negedge clk);
    while (!cpu_gnt && n < 16) begin
      n++;
      @(negedge clk);
    end
    check("cpu grant within bound", 32'(cpu_gnt), 32'd1);
    stepIn();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b1; disp_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; disp_addr = '0;

    // Reset with both requesters active.
    repeat (3) begin
      @(negedge clk);
      check("rst cpu_gnt",  32'(cpu_gnt),  32'd0);
      check("rst disp_gnt", 32'(disp_gnt), 32'd0);
      check("rst mem_en",   32'(mem_en),   32'd0);
      check("rst rvalid",   32'({cpu_rvalid, disp_rvalid}), 32'd0);
    end
    stepIn();
    rst = 1'b0; cpu_req = 1'b0; disp_req = 1'b0;
    stepIn();

    // CPU write then read of 0x0010.
    cpuOp(1'b1, 16'h0010, 32'hDEADBEEF);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    @(negedge clk);
    check("t2 cpu_gnt",  32'(cpu_gnt),  32'd1);
    check("t2 mem_addr", 32'(mem_addr), 32'h0004);
    stepIn();
    cpu_req = 1'b0;
    @(negedge clk);
    check("t2 cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("t2 cpu_rdata",  cpu_rdata,       32'hDEADBEEF);
    stepIn();

    // Display reads, back-to-back at 0x13 then 0x10.
    cpuOp(1'b1, 16'h0010, 32'h11223344);
    disp_req = 1'b1; disp_addr = 16'h0013;
    @(negedge clk);
    check("t3 disp_gnt", 32'(disp_gnt), 32'd1);
    stepIn();
    disp_addr = 16'h0010;
    @(negedge clk);
    check("t3 disp_gnt b2b", 32'(disp_gnt),    32'd1);
    check("t3 rvalid 0x13",  32'(disp_rvalid), 32'd1);
    check("t3 rdata 0x13",   32'(disp_rdata),  32'h11);
    stepIn();
    disp_req = 1'b0;
    @(negedge clk);
    check("t3 rvalid 0x10", 32'(disp_rvalid), 32'd1);
    check("t3 rdata 0x10",  32'(disp_rdata),  32'h44);
    stepIn();

    // Contention for 8 cycles: C,C,C,D,C,C,C,D.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    disp_req = 1'b1; disp_addr = 16'h0012;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4 disp_gnt", 32'(disp_gnt), 32'((i % 4) == 3));
      check("t4 cpu_gnt",  32'(cpu_gnt),  32'((i % 4) != 3));
    end
    stepIn();
    cpu_req = 1'b0; disp_req = 1'b0;
    @(negedge clk);
`ifdef ARB_STATS_EN
    check("t6 stat_conflicts", 32'(stat_conflicts), 32'd8);
    check("t6 stat_forced",    32'(stat_forced),    32'd2);
`endif
    stepIn();

    // Write then display byte read.
    cpuOp(1'b1, 16'h0020, 32'hCAFEF00D);
    @(negedge clk);
    check("t5 no rvalid after write", 32'(cpu_rvalid), 32'd0);
    disp_req = 1'b1; disp_addr = 16'h0021;
    @(negedge clk);
    check("t5 disp_gnt", 32'(disp_gnt), 32'd1);
    stepIn();
    disp_req = 1'b0;
    @(negedge clk);
    check("t5 disp_rvalid", 32'(disp_rvalid), 32'd1);
    check("t5 disp_rdata",  32'(disp_rdata),  32'hF0);
    stepIn();

    // Reset while a display read is in flight.
    disp_req = 1'b1; disp_addr = 16'h0021;
    @(negedge clk);
    check("t6 disp_gnt", 32'(disp_gnt), 32'd1);
    stepIn();
    disp_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t6 rvalid in rst", 32'(disp_rvalid), 32'd0);
    stepIn();
    rst = 1'b0;
    @(negedge clk);
    check("t6 rvalid after rst", 32'(disp_rvalid), 32'd0);
    check("t6 rdata cleared",    32'(disp_rdata),  32'd0);
    stepIn();
    repeat (3) stepIn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
